// File: rtl/fcore_trace_buffer.sv
// Trace capture for the fCore pipeline: instruction, round-marker and DMA events
// go into a circular BRAM of 3-word entries, drained later as a ready/valid word stream.
module fcore_trace_buffer #(
  parameter int PC_WIDTH     = 12,
  parameter int MAX_CHANNELS = 255,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  localparam int CH_W        = $clog2(MAX_CHANNELS),
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  arm_i,
  input  logic                  mode_i,
  input  logic                  filter_enable_i,
  input  logic [CH_W-1:0]       filter_channel_i,
  input  logic                  start_i,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] instr_data_i,
  input  logic [PC_WIDTH-1:0]   instr_pc_i,
  input  logic [CH_W-1:0]       instr_channel_i,
  input  logic [DATA_WIDTH-1:0] result_data_i,
  input  logic                  dma_valid_i,
  input  logic [DATA_WIDTH-1:0] dma_data_i,
  input  logic [CH_W-1:0]       dma_dest_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic [AW:0]           fill_level_o,
  output logic [15:0]           drop_count_o,
  output logic                  frozen_o
);

  localparam int          EW       = 3 * DATA_WIDTH;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] FILL_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [1:0]  T_INSTR  = 2'd0;
  localparam logic [1:0]  T_START  = 2'd1;
  localparam logic [1:0]  T_FINISH = 2'd2;
  localparam logic [1:0]  T_DMA    = 2'd3;

  typedef enum logic [1:0] {C_DISARMED, C_CAPTURING, C_FROZEN} cap_state_e;
  typedef enum logic {R_IDLE, R_RUNNING} round_state_e;

  cap_state_e                cap_q;
  round_state_e              round_q;
  logic [CH_W+PC_WIDTH-1:0]  prev_addr_q;
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             rd_ptr_q;
  logic [AW:0]               fill_q;
  logic [15:0]               drop_q;
  logic                      frozen_q;
  logic [EW-1:0]             mem [DEPTH];
  logic [EW-1:0]             rd_entry_q;
  logic                      rd_pend_q;
  logic [1:0]                word_idx_q;
  logic [DATA_WIDTH-1:0]     out_data_q;
  logic                      out_valid_q;
  logic                      out_last_q;

  logic [CH_W+PC_WIDTH-1:0]  addr_now;
  logic                      running, fin_ev, start_ev, instr_ev, dma_ev, any_ev;
  logic                      full, capture_ok, wr_en, lost, overwrite;
  logic [1:0]                drop_inc;
  logic [16:0]               drop_sum;
  logic [15:0]               drop_d;
  logic                      readable, hs, last_hs, rd_issue;
  logic [AW-1:0]             rd_addr;
  logic [1:0]                type_d;
  logic [CH_W-1:0]           chan_d;
  logic [PC_WIDTH-1:0]       pc_d;
  logic [DATA_WIDTH-1:0]     w0_d, w1_d, w2_d;

  assign addr_now = {instr_channel_i, instr_pc_i};
  assign running  = (round_q == R_RUNNING);
  assign fin_ev   = running & done_i;
  assign start_ev = ~running & start_i;
  assign instr_ev = running & (addr_now != prev_addr_q) &
                    (~filter_enable_i | (instr_channel_i == filter_channel_i));
  assign dma_ev   = ~running & dma_valid_i;
  assign any_ev   = fin_ev | start_ev | instr_ev | dma_ev;

  // A one-shot buffer that is full accepts nothing and counts nothing.
  assign full       = (fill_q == FULL_LVL);
  assign capture_ok = (cap_q == C_CAPTURING) & ~(mode_i & full);
  assign wr_en      = capture_ok & any_ev;
  // Only one event of each round phase can collide with another.
  assign lost       = (fin_ev & instr_ev) | (start_ev & dma_ev);
  assign overwrite  = wr_en & full;

  assign drop_inc = {1'b0, capture_ok & lost} + {1'b0, overwrite};
  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_comb begin
    type_d = T_DMA;
    chan_d = dma_dest_i;
    pc_d   = '0;
    w1_d   = dma_data_i;
    w2_d   = '0;
    if (fin_ev) begin
      type_d = T_FINISH;
      chan_d = '0;
      w1_d   = '0;
    end else if (start_ev) begin
      type_d = T_START;
      chan_d = '0;
      w1_d   = '0;
    end else if (instr_ev) begin
      type_d = T_INSTR;
      chan_d = instr_channel_i;
      pc_d   = instr_pc_i;
      w1_d   = instr_data_i;
      w2_d   = result_data_i;
    end
    w0_d = '0;
    w0_d[PC_WIDTH-1:0]          = pc_d;
    w0_d[PC_WIDTH +: CH_W]      = chan_d;
    w0_d[PC_WIDTH + CH_W +: 2]  = type_d;
  end

  assign readable = ((cap_q == C_DISARMED) & ~arm_i) | (cap_q == C_FROZEN);
  assign hs       = out_valid_q & out_ready_i;
  assign last_hs  = hs & (word_idx_q == 2'd2);
  // Prefetch the next entry on the final handshake so entries are one bubble apart.
  assign rd_issue = readable & ~rd_pend_q &
                    ((~out_valid_q & (fill_q != '0)) | (last_hs & (fill_q > FILL_ONE)));
  assign rd_addr  = last_hs ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= {w2_d, w1_d, w0_d};
    if (rd_issue) rd_entry_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cap_q       <= C_DISARMED;
      round_q     <= R_IDLE;
      prev_addr_q <= '1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      drop_q      <= '0;
      frozen_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      word_idx_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      prev_addr_q <= addr_now;
      case (round_q)
        R_IDLE:    if (start_i) round_q <= R_RUNNING;
        R_RUNNING: if (done_i)  round_q <= R_IDLE;
      endcase

      if ((cap_q == C_DISARMED) && arm_i) begin
        cap_q       <= C_CAPTURING;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        fill_q      <= '0;
        drop_q      <= '0;
        frozen_q    <= 1'b0;
        rd_pend_q   <= 1'b0;
        word_idx_q  <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (cap_q)
          C_CAPTURING: begin
            if (!arm_i) begin
              cap_q <= C_DISARMED;
            end else if (mode_i && full) begin
              cap_q    <= C_FROZEN;
              frozen_q <= 1'b1;
            end
          end
          C_FROZEN: if (!arm_i) cap_q <= C_DISARMED;
          default: ;
        endcase

        if (wr_en) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
          if (full) rd_ptr_q <= rd_ptr_q + PTR_ONE;
          else      fill_q   <= fill_q + FILL_ONE;
        end
        drop_q    <= drop_d;
        rd_pend_q <= rd_issue;

        if (readable) begin
          if (rd_pend_q) begin
            out_data_q  <= rd_entry_q[0 +: DATA_WIDTH];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            word_idx_q  <= 2'd0;
          end else if (hs) begin
            if (word_idx_q == 2'd2) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_ptr_q    <= rd_ptr_q + PTR_ONE;
              fill_q      <= fill_q - FILL_ONE;
            end else begin
              out_data_q  <= (word_idx_q == 2'd0) ? rd_entry_q[DATA_WIDTH +: DATA_WIDTH]
                                                  : rd_entry_q[2*DATA_WIDTH +: DATA_WIDTH];
              out_last_q  <= (word_idx_q == 2'd1);
              word_idx_q  <= word_idx_q + 2'd1;
            end
          end
        end
      end
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign fill_level_o = fill_q;
  assign drop_count_o = drop_q;
  assign frozen_o     = frozen_q;

endmodule

// File: tb/tb_fcore_trace_buffer.sv
// Randomized bench for fcore_trace_buffer against a queue-based reference model
// of the capture, drop and readout rules.
module tb_fcore_trace_buffer;
  localparam int PCW   = 12;
  localparam int CHW   = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef logic [3*DW-1:0] ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, arm, mode, fen, start, done, dvalid, out_ready;
  logic [CHW-1:0] fch, ich, ddest;
  logic [PCW-1:0] ipc;
  logic [DW-1:0]  idata, rdata, ddata;
  logic [DW-1:0]  out_data;
  logic           out_valid, out_last, frozen;
  logic [3:0]     fill;
  logic [15:0]    drop;

  fcore_trace_buffer #(
    .PC_WIDTH(PCW), .MAX_CHANNELS(255), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .reset_i(reset), .arm_i(arm), .mode_i(mode),
    .filter_enable_i(fen), .filter_channel_i(fch),
    .start_i(start), .done_i(done),
    .instr_data_i(idata), .instr_pc_i(ipc), .instr_channel_i(ich),
    .result_data_i(rdata),
    .dma_valid_i(dvalid), .dma_data_i(ddata), .dma_dest_i(ddest),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last),
    .out_ready_i(out_ready),
    .fill_level_o(fill), .drop_count_o(drop), .frozen_o(frozen)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model: entries as a queue, capture state 0=disarmed 1=capturing 2=frozen.
  ent_t             q[$];
  int               cap_m = 0;
  bit               run_m = 0;
  logic [CHW+PCW-1:0] prev_m = '1;
  int               drop_m = 0;
  bit               frz_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input int typ, input int ch, input int pc,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    logic [DW-1:0] w0;
    w0 = DW'(typ * (1 << (CHW + PCW)) + ch * (1 << PCW) + pc);
    return {d2, d1, w0};
  endfunction

  function automatic void model_step();
    bit fin, st, ins, dm, full_pre;
    int nev;
    ent_t e;
    if (reset) begin
      q.delete();
      cap_m = 0; run_m = 0; prev_m = '1; drop_m = 0; frz_m = 0;
      return;
    end
    fin = run_m && done;
    st  = !run_m && start;
    ins = run_m && ({ich, ipc} != prev_m) && (!fen || ich == fch);
    dm  = !run_m && dvalid;
    nev = int'(fin) + int'(st) + int'(ins) + int'(dm);
    full_pre = (q.size() == DEPTH);
    if (cap_m == 1 && !(mode && full_pre) && nev > 0) begin
      if (fin)      e = mk(2, 0, 0, '0, '0);
      else if (st)  e = mk(1, 0, 0, '0, '0);
      else if (ins) e = mk(0, int'(ich), int'(ipc), idata, rdata);
      else          e = mk(3, int'(ddest), 0, ddata, '0);
      if (full_pre) begin
        void'(q.pop_front());
        drop_m++;
      end
      q.push_back(e);
      drop_m += nev - 1;
      if (drop_m > 65535) drop_m = 65535;
    end
    case (cap_m)
      0: if (arm) begin cap_m = 1; q.delete(); drop_m = 0; frz_m = 0; end
      1: if (!arm) cap_m = 0;
         else if (mode && full_pre) begin cap_m = 2; frz_m = 1; end
      default: if (!arm) cap_m = 0;
    endcase
    if (!run_m && start) run_m = 1;
    else if (run_m && done) run_m = 0;
    prev_m = {ich, ipc};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input int ch, input int pc);
    ich = CHW'(ch); ipc = PCW'(pc); idata = $urandom; rdata = $urandom;
    tick();
  endtask

  // Drain every modelled entry; rmode 0 = ready high, 1 = toggling, 2 = random.
  task automatic drain(input int rmode);
    int budget = 0;
    int w = 0;
    bit stalled = 0;
    bit popped = 0;
    logic [DW-1:0] held = '0;
    ent_t e;
    while (q.size() > 0 && budget < 400) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (budget % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        chk("stall_data", out_data, held);
        chk("stall_valid", 32'(out_valid), 32'd1);
        stalled = 0;
      end
      if (out_valid) begin
        e = q[0];
        if (out_ready) begin
          chk("rd_word", out_data, e[w*DW +: DW]);
          chk("rd_last", 32'(out_last), 32'(w == 2));
          w++;
          if (w == 3) begin
            $display("entry: w0=%h w1=%h w2=%h", e[DW-1:0], e[2*DW-1:DW], e[3*DW-1:2*DW]);
            void'(q.pop_front());
            w = 0;
            popped = 1;
          end
        end else begin
          held = out_data;
          stalled = 1;
        end
      end
      tick();
      budget++;
      if (popped) begin
        chk("rd_fill", 32'(fill), 32'(q.size()));
        popped = 0;
      end
    end
    if (budget >= 400) chk("drain_timeout", 32'(budget), 32'd0);
    out_ready = 1'b0;
    tick();
    tick();
    chk("drain_valid_idle", 32'(out_valid), 32'd0);
    chk("drain_fill_zero", 32'(fill), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1; arm = 0; mode = 0; fen = 0; fch = '0; start = 0; done = 0;
    ich = '0; ipc = '0; idata = '0; rdata = '0;
    dvalid = 0; ddata = '0; ddest = '0; out_ready = 0;
    tick();
    tick();
    reset = 0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);

    // Continuous capture of one round
    mode = 0; arm = 1; tick();
    ich = 2; ipc = 0; start = 1; tick(); start = 0;
    instr(2, 'h10); instr(2, 'h11); instr(2, 'h12);
    done = 1; tick(); done = 0;
    chk("t1_fill", 32'(fill), 32'd5);
    arm = 0; tick();
    chk("t1_lat0", 32'(out_valid), 32'd0);
    tick();
    chk("t1_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("t1_lat2", 32'(out_valid), 32'd1);
    chk("t1_first_w0", out_data, 32'h0000_0000 | (32'd1 << 20));
    drain(0);

    // Wrap-around: round started while disarmed, 12 records into 8 slots
    start = 1; tick(); start = 0;
    arm = 1; tick();
    for (int i = 0; i < 12; i++) instr(2, 'h100 + i);
    chk("t2_fill", 32'(fill), 32'd8);
    chk("t2_drop", 32'(drop), 32'd4);
    chk("t2_drop_model", 32'(drop), 32'(drop_m));
    arm = 0; tick();
    drain(2);
    done = 1; tick(); done = 0;

    // One-shot freeze
    start = 1; tick(); start = 0;
    mode = 1; arm = 1; tick();
    for (int i = 0; i < 12; i++) instr($urandom_range(0, 254), 'h200 + i);
    chk("t3_frozen", 32'(frozen), 32'd1);
    chk("t3_fill", 32'(fill), 32'd8);
    chk("t3_drop", 32'(drop), 32'd0);
    arm = 0; tick();
    chk("t3_frozen_dis", 32'(frozen), 32'(frz_m));
    drain(0);
    chk("t3_frozen_after", 32'(frozen), 32'd1);
    done = 1; tick(); done = 0;
    mode = 0;

    // Channel filter and finish/instruction collision
    fen = 1; fch = 3; arm = 1; tick();
    chk("t4_frozen_clr", 32'(frozen), 32'd0);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) instr((i % 2 == 1) ? 3 : 1, 'h300 + i);
    ich = 3; ipc = 'h3ff; idata = $urandom; rdata = $urandom; done = 1; tick(); done = 0;
    chk("t4_drop", 32'(drop), 32'd1);
    chk("t4_fill", 32'(fill), 32'd6);
    arm = 0; tick();
    fen = 0;
    drain(1);

    // DMA capture and backpressure
    arm = 1; tick();
    dvalid = 1; ddata = 32'hDEADBEEF; ddest = 5; tick();
    for (int i = 0; i < 3; i++) begin
      ddata = $urandom; ddest = CHW'($urandom_range(0, 254)); tick();
    end
    start = 1; tick(); start = 0; dvalid = 0;
    done = 1; tick(); done = 0;
    chk("t5_fill", 32'(fill), 32'd6);
    chk("t5_drop", 32'(drop), 32'd1);
    arm = 0; tick();
    drain(1);

    // Abort mid-entry by re-arming, then reset mid-capture
    arm = 1; tick();
    dvalid = 1;
    for (int i = 0; i < 3; i++) begin
      ddata = $urandom; ddest = CHW'($urandom_range(0, 254)); tick();
    end
    dvalid = 0; arm = 0; tick();
    out_ready = 1;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    if (n >= 10) chk("ab_timeout", 32'(n), 32'd0);
    chk("ab_w0", out_data, q[0][DW-1:0]);
    tick();
    chk("ab_w1", out_data, q[0][2*DW-1:DW]);
    tick();
    chk("ab_w2_valid", 32'(out_valid), 32'd1);
    arm = 1; out_ready = 0; tick();
    chk("ab_valid", 32'(out_valid), 32'd0);
    chk("ab_fill", 32'(fill), 32'(q.size()));
    dvalid = 1; ddata = $urandom; tick(); ddata = $urandom; tick(); dvalid = 0;
    chk("ab_fill2", 32'(fill), 32'd2);
    reset = 1; tick(); reset = 0;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_last", 32'(out_last), 32'd0);
    chk("rst2_data", out_data, 32'd0);
    chk("rst2_fill", 32'(fill), 32'd0);
    chk("rst2_drop", 32'(drop), 32'd0);
    chk("rst2_frozen", 32'(frozen), 32'd0);

    // Empty buffer never presents data
    arm = 1; tick(); arm = 0; tick();
    out_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_fill", 32'(fill), 32'(q.size()));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
